// File: rtl/booth_mul_sched.sv
// Round-robin front end sharing one sequential radix-2 Booth multiplier among NREQ requesters.
// One Booth step per clock; product returned with a one-cycle done pulse to the granted requester.
module booth_mul_sched #(
    parameter int W    = 4,
    parameter int NREQ = 2,
    parameter int CW   = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req,
    input  logic [NREQ*W-1:0] a_in,
    input  logic [NREQ*W-1:0] b_in,
    output logic [NREQ-1:0]   gnt,
    output logic              busy,
    output logic [NREQ-1:0]   done,
    output logic [2*W-1:0]    c
);
    localparam int PW = (NREQ > 2) ? 2 : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t          state_q, state_d;
    logic [PW-1:0]   ptr_q, ptr_d;
    logic [PW-1:0]   owner_q, owner_d;
    logic [W:0]      m_q, m_d;
    logic [W:0]      acc_q, acc_d;
    logic [W-1:0]    q_q, q_d;
    logic            q1_q, q1_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [NREQ-1:0] gnt_q, gnt_d;
    logic [NREQ-1:0] done_q, done_d;
    logic [2*W-1:0]  c_q, c_d;

    logic            found;
    logic [PW-1:0]   win;
    logic [W-1:0]    a_sel, b_sel;
    logic [W:0]      sum;

    // Pointer position has top priority; scan upward with wrap.
    always_comb begin
        found = 1'b0;
        win   = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (!found && req[(int'(ptr_q) + k) % NREQ]) begin
                found = 1'b1;
                win   = PW'((int'(ptr_q) + k) % NREQ);
            end
        end
    end

    assign a_sel = a_in[int'(win)*W +: W];
    assign b_sel = b_in[int'(win)*W +: W];

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        owner_d = owner_q;
        m_d     = m_q;
        acc_d   = acc_q;
        q_d     = q_q;
        q1_d    = q1_q;
        cnt_d   = cnt_q;
        gnt_d   = '0;
        done_d  = '0;
        c_d     = c_q;
        sum     = acc_q;
        case (state_q)
            IDLE: begin
                if (found) begin
                    m_d        = {a_sel[W-1], a_sel};
                    q_d        = b_sel;
                    q1_d       = 1'b0;
                    acc_d      = '0;
                    cnt_d      = '0;
                    owner_d    = win;
                    gnt_d[win] = 1'b1;
                    ptr_d      = (win == PW'(NREQ-1)) ? '0 : win + PW'(1);
                    state_d    = RUN;
                end
            end
            RUN: begin
                // acc carries one guard bit so M = -2^(W-1) negates without overflow.
                case ({q_q[0], q1_q})
                    2'b01:   sum = acc_q + m_q;
                    2'b10:   sum = acc_q - m_q;
                    default: sum = acc_q;
                endcase
                acc_d = {sum[W], sum[W:1]};
                q_d   = {sum[0], q_q[W-1:1]};
                q1_d  = q_q[0];
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(W-1)) state_d = DONE;
            end
            DONE: begin
                c_d             = {acc_q[W-1:0], q_q};
                done_d[owner_q] = 1'b1;
                state_d         = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            owner_q <= '0;
            m_q     <= '0;
            acc_q   <= '0;
            q_q     <= '0;
            q1_q    <= 1'b0;
            cnt_q   <= '0;
            gnt_q   <= '0;
            done_q  <= '0;
            c_q     <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            owner_q <= owner_d;
            m_q     <= m_d;
            acc_q   <= acc_d;
            q_q     <= q_d;
            q1_q    <= q1_d;
            cnt_q   <= cnt_d;
            gnt_q   <= gnt_d;
            done_q  <= done_d;
            c_q     <= c_d;
        end
    end

    assign gnt  = gnt_q;
    assign done = done_q;
    assign c    = c_q;
    assign busy = (state_q != IDLE);
endmodule

// File: tb/tb_booth_mul_sched.sv
// Scoreboard bench for booth_mul_sched: stimulus pushes expected grants/products,
// a negedge monitor pops and compares whenever gnt or done is presented.
module tb_booth_mul_sched;
    localparam int W    = 4;
    localparam int NREQ = 2;
    localparam int CW   = 3;

    logic              clk;
    logic              rst;
    logic [NREQ-1:0]   req;
    logic [NREQ*W-1:0] a_in, b_in;
    logic [NREQ-1:0]   gnt, done;
    logic              busy;
    logic [2*W-1:0]    c;

    booth_mul_sched #(.W(W), .NREQ(NREQ), .CW(CW)) dut (
        .clk(clk), .rst(rst), .req(req), .a_in(a_in), .b_in(b_in),
        .gnt(gnt), .busy(busy), .done(done), .c(c)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;
    int last_gnt_cyc = 0;

    int             exp_gnt_q[$];
    int             exp_done_q[$];
    logic [2*W-1:0] exp_c_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic set_op(input int i, input logic [W-1:0] a, input logic [W-1:0] b);
        a_in[i*W +: W] = a;
        b_in[i*W +: W] = b;
    endtask

    task automatic expect_job(input int i, input logic [2*W-1:0] prod);
        exp_gnt_q.push_back(i);
        exp_done_q.push_back(i);
        exp_c_q.push_back(prod);
    endtask

    // Waits at negedge for any gnt bit; an expired bound counts as a failure.
    task automatic wait_gnt(input string name, output int at_cyc);
        int n;
        n = 0;
        at_cyc = -1;
        @(negedge clk);
        while (gnt == '0 && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (gnt == '0) begin
            tests++; fails++;
            $display("FAIL %s: timeout waiting for gnt", name);
        end else begin
            at_cyc = cyc;
        end
    endtask

    task automatic wait_done(input string name);
        int n;
        n = 0;
        @(negedge clk);
        while (done == '0 && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (done == '0) begin
            tests++; fails++;
            $display("FAIL %s: timeout waiting for done", name);
        end
        @(negedge clk);
    endtask

    task automatic run_single(input int i, input logic [W-1:0] a, input logic [W-1:0] b,
                              input logic [2*W-1:0] prod, input string name);
        int gc;
        set_op(i, a, b);
        expect_job(i, prod);
        req[i] = 1'b1;
        wait_gnt(name, gc);
        req[i] = 1'b0;
        wait_done(name);
    endtask

    // Monitor: compares every presented gnt/done against the scoreboard.
    initial begin
        int ei;
        logic [2*W-1:0] ec;
        forever begin
            @(negedge clk);
            cyc++;
            if (rst) begin
                if (gnt != '0 && done != '0) begin
                    tests++; fails++;
                    $display("FAIL gnt_done_overlap: gnt %b done %b", gnt, done);
                end
                if (gnt != '0) begin
                    if (exp_gnt_q.size() == 0) begin
                        tests++; fails++;
                        $display("FAIL unexpected_gnt: got %b expected none", gnt);
                    end else begin
                        ei = exp_gnt_q.pop_front();
                        chk("gnt_onehot", 32'(gnt), 32'(1 << ei));
                    end
                    last_gnt_cyc = cyc;
                end
                if (done != '0) begin
                    if (exp_done_q.size() == 0) begin
                        tests++; fails++;
                        $display("FAIL unexpected_done: got %b expected none", done);
                    end else begin
                        ei = exp_done_q.pop_front();
                        ec = exp_c_q.pop_front();
                        chk("done_owner", 32'(done), 32'(1 << ei));
                        chk("product", 32'(c), 32'(ec));
                        chk("done_latency", 32'(cyc - last_gnt_cyc), 32'(W + 1));
                    end
                end
            end
        end
    end

    initial begin
        int g[4];
        logic [2*W-1:0] c_hold;
        rst  = 1'b0;
        req  = '0;
        a_in = '0;
        b_in = '0;
        repeat (2) @(negedge clk);
        chk("rst_gnt", 32'(gnt), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_c", 32'(c), 0);
        rst = 1'b1;
        @(negedge clk);

        run_single(0, 4'd3, 4'hE, 8'hFA, "r0_3x-2");
        run_single(1, 4'h8, 4'h8, 8'h40, "r1_-8x-8");
        run_single(1, 4'h8, 4'h7, 8'hC8, "r1_-8x7");
        run_single(1, 4'h7, 4'h7, 8'h31, "r1_7x7");
        run_single(1, 4'h0, 4'hB, 8'h00, "r1_0x-5");

        // Both requesters continuously active: pointer is 0 here.
        set_op(0, 4'd2, 4'd3);
        set_op(1, 4'hF, 4'd4);
        expect_job(0, 8'h06);
        expect_job(1, 8'hFC);
        expect_job(0, 8'h06);
        expect_job(1, 8'hFC);
        req = 2'b11;
        for (int k = 0; k < 4; k++) wait_gnt("rr_gnt", g[k]);
        req = 2'b00;
        for (int k = 1; k < 4; k++) chk("rr_spacing", 32'(g[k] - g[k-1]), 32'(W + 2));
        wait_done("rr_last");

        // Operands changed and req dropped during own job: captured operands win.
        set_op(1, 4'd3, 4'd5);
        expect_job(1, 8'h0F);
        req[1] = 1'b1;
        wait_gnt("drop_gnt", g[0]);
        set_op(1, 4'd7, 4'd7);
        @(negedge clk);
        req[1] = 1'b0;
        wait_done("drop_done");
        repeat (8) @(negedge clk);

        // Reset two cycles into RUN aborts the job silently.
        set_op(0, 4'd2, 4'd2);
        exp_gnt_q.push_back(0);
        req[0] = 1'b1;
        wait_gnt("abort_gnt", g[0]);
        req[0] = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("abort_gnt", 32'(gnt), 0);
        chk("abort_done", 32'(done), 0);
        chk("abort_busy", 32'(busy), 0);
        chk("abort_c", 32'(c), 0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        set_op(0, 4'hD, 4'd5);
        set_op(1, 4'd1, 4'd1);
        expect_job(0, 8'hF1);
        req = 2'b11;
        wait_gnt("post_rst_gnt", g[0]);
        req = 2'b00;
        wait_done("post_rst_done");

        // Idle: nothing moves, c holds.
        c_hold = 8'hF1;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            chk("idle_quiet", {busy, 2'(gnt), 2'(done)}, 0);
            chk("idle_c_hold", 32'(c), 32'(c_hold));
        end

        chk("sb_gnt_empty", 32'(exp_gnt_q.size()), 0);
        chk("sb_done_empty", 32'(exp_done_q.size()), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
